fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction ROM. Owns the program counter, drives the ROM's `CE`/`OE`/`PCadr` strobes, captures the returned 16-bit `instruction` into an instruction register, and hands it to decode over a valid/ready handshake. Branch/jump redirects from execute squash any fetch in flight.

## Interface
Parameters:
- `ADDR_W`, default 12: PC / ROM address width.
- `INSTR_W`, default 16: instruction width.
- `RESET_PC`, default 12'h000: PC value loaded on reset.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `CE`  out  1: ROM chip enable, active-high.
- `OE`  out  1: ROM output enable, active-high.
- `PCadr`  out  ADDR_W: ROM address; always equals the PC register.
- `instruction`  in  INSTR_W: ROM read data, valid one cycle after the `CE`/`OE` cycle.
- `ir`  out  INSTR_W: captured instruction.
- `ir_pc`  out  ADDR_W: address `ir` was fetched from.
- `ir_valid`  out  1: `ir`/`ir_pc` hold an instruction for decode.
- `ir_ready`  in  1: decode accepts; transfer occurs on an edge with `ir_valid && ir_ready`.
- `branch_en`  in  1: redirect request, single-cycle pulse.
- `branch_target`  in  ADDR_W: new PC when `branch_en` is high.

## Operation
- FSM states: `IDLE`, `FETCH`, `LATCH`, `HOLD`.
- `IDLE`: entered on reset; goes to `FETCH` on the next edge.
- `FETCH`: `CE = OE = 1`, `PCadr = pc`; goes to `LATCH`.
- `LATCH`: ROM data is on `instruction`. At the edge: `ir <= instruction`, `ir_pc <= pc`, `pc <= pc + 1`, `ir_valid <= 1`; goes to `HOLD`.
- `HOLD`: `ir_valid = 1`, `ir`/`ir_pc` stable. On transfer: `ir_valid <= 0`, go to `FETCH`. Without `ir_ready`, stay in `HOLD` indefinitely.
- `CE`/`OE` are a combinational decode of `state == FETCH` and are low in every other state.
- PC increment is modulo 2^ADDR_W: 12'hFFF wraps to 12'h000 with no flag.
- Priority at each edge: `reset` > `branch_en` > normal FSM.
- `branch_en` in any state: `pc <= branch_target`, `ir_valid <= 0`, state goes to `FETCH`. A ROM read in flight (state `LATCH`) is discarded and `ir` is not updated.
- `branch_en` with a transfer in `HOLD`: the transfer counts (decode consumed `ir`), then the redirect applies.
- `branch_en` while `ir_ready` is low in `HOLD`: the held instruction is dropped.
- `reset` mid-operation: all state returns to reset values on that edge regardless of other inputs. An in-flight ROM read is ignored.

## Timing
- Reset values: state `IDLE`, `pc = RESET_PC` (so `PCadr = RESET_PC`), `CE = 0`, `OE = 0`, `ir = 0`, `ir_pc = 0`, `ir_valid = 0`.
- First `CE`/`OE` pulse: 2nd cycle after `reset` deasserts. First `ir_valid`: 4th cycle.
- ROM latency is 1 cycle. Fetch-to-`ir_valid` is 2 edges after the `FETCH` cycle.
- Throughput with `ir_ready` held high: 1 instruction per 3 cycles.
- Branch-to-`CE`: `FETCH` of `branch_target` in the cycle after `branch_en`. `ir_valid` at `branch_target` 2 cycles later.
- `ir`/`ir_pc` change only on the `LATCH` edge. They are stable throughout `HOLD`.

## Structure
- Package `fetch_pkg` holds:
  - `ADDR_W` and `INSTR_W` defaults;
  - `RESET_PC`;
  - the `fetch_state_t` enum (`IDLE`, `FETCH`, `LATCH`, `HOLD`).
- Single module with no sub-module; the PC, FSM and IR are tightly coupled.
- Benches instantiate the existing `ROM` as the memory model.

## Test plan
- Reset with `ir_ready = 1`, ROM preloaded with `mem[i] = 16'hA000 + i` → `CE` high at cycles 2, 5, 8; `ir` = 16'hA000, 16'hA001, 16'hA002 with `ir_pc` = 0, 1, 2.
- `ir_ready = 0` for 10 cycles after first `ir_valid` → `ir_valid` stays 1, `ir` stays 16'hA000, `CE` stays 0; raising `ir_ready` → transfer, then `FETCH` of address 1.
- `branch_en`, `branch_target = 12'h080` during `LATCH` of address 5 → `mem[5]` never appears; next `ir_pc = 12'h080`.
- `branch_en` coincident with a transfer in `HOLD` → the transfer completes, `ir_valid` drops, next `PCadr = branch_target`.
- Branch to 12'hFFF, `ir_ready = 1` → `ir_pc` 12'hFFF, then 12'h000 (wrap).
- `reset` asserted during `HOLD` with `ir_valid = 1` → next cycle `ir_valid = 0`, `PCadr = RESET_PC`, `CE = 0`; normal fetch resumes after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module  : fetch_pkg
// Purpose : Shared defaults and FSM state encoding for the instruction fetch
//           stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  // Default PC / ROM address width
  localparam int DEFAULT_ADDR_W  = 12;
  // Default instruction word width
  localparam int DEFAULT_INSTR_W = 16;
  // Default PC value loaded on reset
  localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_PC = 12'h000;

  // Fetch sequencer states: one ROM access takes FETCH then LATCH, and the
  // captured word is presented to decode in HOLD until it is accepted.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Purpose : Instruction fetch stage. Owns the PC, strobes the instruction ROM,
//           captures the returned word into the instruction register and
//           presents it to decode over a valid/ready handshake. Branch
//           redirects squash any fetch in flight.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
  input  logic               clk,
  input  logic               reset,
  output logic               CE,
  output logic               OE,
  output logic [ADDR_W-1:0]  PCadr,
  input  logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target
);

  localparam logic [ADDR_W-1:0] c_pc_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_t         r_state;
  fetch_state_t         w_next_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    w_next_pc;
  logic [INSTR_W-1:0]   r_ir;
  logic [ADDR_W-1:0]    r_ir_pc;
  logic                 r_ir_valid;
  logic                 w_next_valid;
  logic                 w_load_ir;
  logic                 w_transfer;

  // Decode consumes the held word on any edge where both sides agree
  assign w_transfer = r_ir_valid && ir_ready;

  // State, PC and instruction register update; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_ir_valid <= w_next_valid;
      if (w_load_ir) begin
        r_ir    <= instruction;
        r_ir_pc <= r_pc;
      end
    end
  end

  // Next-state decode; a redirect overrides the sequencer in every state and
  // suppresses the IR load so an in-flight ROM word is discarded
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_valid = r_ir_valid;
    w_load_ir    = 1'b0;
    if (branch_en) begin
      w_next_state = FETCH;
      w_next_pc    = branch_target;
      w_next_valid = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_next_state = FETCH;
        end
        FETCH: begin
          w_next_state = LATCH;
        end
        LATCH: begin
          // ROM data is on the bus now; PC wraps naturally at 2^ADDR_W
          w_load_ir    = 1'b1;
          w_next_pc    = r_pc + c_pc_one;
          w_next_valid = 1'b1;
          w_next_state = HOLD;
        end
        HOLD: begin
          if (w_transfer) begin
            w_next_valid = 1'b0;
            w_next_state = FETCH;
          end
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // ROM strobes are a pure decode of the FETCH state
  assign CE       = (r_state == FETCH);
  assign OE       = (r_state == FETCH);
  assign PCadr    = r_pc;
  assign ir       = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_valid;

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Directed self-checking bench for fetch_unit with a 1-cycle
//           registered-read ROM model holding mem[i] = 16'hA000 + i.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        CE;
  logic        OE;
  logic [11:0] PCadr;
  logic [15:0] instruction;
  logic [15:0] ir;
  logic [11:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        branch_en;
  logic [11:0] branch_target;

  int errors;
  int checks;

  logic [15:0] mem [0:4095];

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .CE            (CE),
    .OE            (OE),
    .PCadr         (PCadr),
    .instruction   (instruction),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .branch_en     (branch_en),
    .branch_target (branch_target)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: data appears the cycle after the CE/OE cycle
  always @(posedge clk) begin
    if (CE && OE) instruction <= mem[PCadr];
  end

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (CE !== 1'b0 || OE !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: CE=%b OE=%b expected 0 0", CE, OE);
    end
    checks++;
    if (PCadr !== 12'h000 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pc_valid: PCadr=%h ir_valid=%b expected 000 0", PCadr, ir_valid);
    end
    checks++;
    if (ir !== 16'h0000 || ir_pc !== 12'h000) begin
      errors++;
      $display("FAIL reset_ir: ir=%h ir_pc=%h expected 0000 000", ir, ir_pc);
    end
  endtask

  // Continuous flow: CE at cycles 2,5,8, ir_valid at 4,7,10
  task automatic test_stream();
    logic        exp_ce;
    logic [15:0] exp_ir;
    reset    = 1'b1;
    ir_ready = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      exp_ce = ((c % 3) == 2);
      checks++;
      if (CE !== exp_ce || OE !== exp_ce) begin
        errors++;
        $display("FAIL stream_ce cycle %0d: CE=%b OE=%b expected %b", c, CE, OE, exp_ce);
      end
      if (c >= 4 && (c % 3) == 1) begin
        exp_ir = 16'hA000 + 16'((c - 4) / 3);
        checks++;
        if (ir_valid !== 1'b1 || ir !== exp_ir || ir_pc !== 12'((c - 4) / 3)) begin
          errors++;
          $display("FAIL stream_ir cycle %0d: valid=%b ir=%h ir_pc=%h expected 1 %h %h",
                   c, ir_valid, ir, ir_pc, exp_ir, 12'((c - 4) / 3));
        end
      end
      step();
    end
  endtask

  // Decode stalls for 10 cycles on the first word, then accepts it
  task automatic test_stall();
    reset    = 1'b1;
    ir_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    step();
    step();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (ir_valid !== 1'b1 || ir !== 16'hA000 || CE !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold %0d: valid=%b ir=%h CE=%b expected 1 a000 0", k, ir_valid, ir, CE);
      end
      step();
    end
    ir_ready = 1'b1;
    step();
    checks++;
    if (ir_valid !== 1'b0 || CE !== 1'b1 || PCadr !== 12'h001) begin
      errors++;
      $display("FAIL stall_release: valid=%b CE=%b PCadr=%h expected 0 1 001", ir_valid, CE, PCadr);
    end
  endtask

  // Redirect during LATCH of address 5 discards mem[5]
  task automatic test_branch_latch();
    int  budget;
    budget = 0;
    while (!(CE === 1'b1 && PCadr === 12'h005) && budget < 50) begin
      step();
      budget++;
    end
    checks++;
    if (budget >= 50) begin
      errors++;
      $display("FAIL branch_latch_find: no FETCH of 005 seen, PCadr=%h", PCadr);
    end
    step();
    branch_en     = 1'b1;
    branch_target = 12'h080;
    step();
    branch_en = 1'b0;
    checks++;
    if (CE !== 1'b1 || PCadr !== 12'h080 || ir_valid !== 1'b0 || ir !== 16'hA004) begin
      errors++;
      $display("FAIL branch_latch_redirect: CE=%b PCadr=%h valid=%b ir=%h expected 1 080 0 a004",
               CE, PCadr, ir_valid, ir);
    end
    step();
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir !== 16'hA080 || ir_pc !== 12'h080) begin
      errors++;
      $display("FAIL branch_latch_target: valid=%b ir=%h ir_pc=%h expected 1 a080 080",
               ir_valid, ir, ir_pc);
    end
  endtask

  // Redirect on the same edge as a transfer in HOLD
  task automatic test_back_to_back();
    ir_ready      = 1'b1;
    branch_en     = 1'b1;
    branch_target = 12'h123;
    step();
    branch_en = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || CE !== 1'b1 || PCadr !== 12'h123 || ir !== 16'hA080) begin
      errors++;
      $display("FAIL b2b_redirect: valid=%b CE=%b PCadr=%h ir=%h expected 0 1 123 a080",
               ir_valid, CE, PCadr, ir);
    end
    step();
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir !== 16'hA123 || ir_pc !== 12'h123) begin
      errors++;
      $display("FAIL b2b_target: valid=%b ir=%h ir_pc=%h expected 1 a123 123", ir_valid, ir, ir_pc);
    end
  endtask

  // PC wraps from FFF to 000
  task automatic test_wrap();
    ir_ready      = 1'b1;
    branch_en     = 1'b1;
    branch_target = 12'hFFF;
    step();
    branch_en = 1'b0;
    step();
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 12'hFFF || ir !== 16'hAFFF) begin
      errors++;
      $display("FAIL wrap_top: valid=%b ir=%h ir_pc=%h expected 1 afff fff", ir_valid, ir, ir_pc);
    end
    step();
    checks++;
    if (CE !== 1'b1 || PCadr !== 12'h000) begin
      errors++;
      $display("FAIL wrap_fetch: CE=%b PCadr=%h expected 1 000", CE, PCadr);
    end
    step();
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 12'h000 || ir !== 16'hA000) begin
      errors++;
      $display("FAIL wrap_zero: valid=%b ir=%h ir_pc=%h expected 1 a000 000", ir_valid, ir, ir_pc);
    end
  endtask

  // Reset while HOLD is presenting a word, then normal restart
  task automatic test_reset_hold();
    ir_ready = 1'b0;
    checks++;
    if (ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_pre: valid=%b expected 1", ir_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || PCadr !== 12'h000 || CE !== 1'b0 || ir !== 16'h0000) begin
      errors++;
      $display("FAIL rst_hold_state: valid=%b PCadr=%h CE=%b ir=%h expected 0 000 0 0000",
               ir_valid, PCadr, CE, ir);
    end
    ir_ready = 1'b1;
    step();
    checks++;
    if (CE !== 1'b1 || PCadr !== 12'h000) begin
      errors++;
      $display("FAIL rst_hold_fetch: CE=%b PCadr=%h expected 1 000", CE, PCadr);
    end
    step();
    step();
    checks++;
    if (ir_valid !== 1'b1 || ir !== 16'hA000 || ir_pc !== 12'h000) begin
      errors++;
      $display("FAIL rst_hold_resume: valid=%b ir=%h ir_pc=%h expected 1 a000 000", ir_valid, ir, ir_pc);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    ir_ready      = 1'b1;
    branch_en     = 1'b0;
    branch_target = 12'h000;
    for (int i = 0; i < 4096; i++) mem[i] = 16'(16'hA000 + i);
    test_reset();
    test_stream();
    test_stall();
    test_branch_latch();
    test_back_to_back();
    test_wrap();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fetch_unit

`default_nettype wire
